// File: rtl/beta_bju_pred_if.sv
// rtl/beta_bju_pred_if.sv - request, result and lookup bundle for the branch/jump unit with predictor
interface beta_bju_pred_if #(
   parameter int DATAWIDTH = 32
);
   // ALU flags selected by the branch condition: [0] eq, [1] lt, [2] ltu, [3] spare
   typedef logic [3:0] exe_alu_status_t;

   typedef struct packed {
      logic [1:0] exe_bju_en;
      logic [1:0] exe_bju_condition_sel;
      logic       exe_bju_condition_neg;
   } exe_bju_op_t;

   logic                 valid_i;
   logic                 ready_o;
   logic [DATAWIDTH-1:0] pc_i;
   logic [11:0]          offset12_i;
   logic [19:0]          offset20_i;
   logic [DATAWIDTH-1:0] basereg_i;
   exe_alu_status_t      alu_stat_i;
   exe_bju_op_t          op_i;
   logic                 pred_taken_i;
   logic                 stall_i;
   logic                 flush_i;
   logic [DATAWIDTH-1:0] lookup_pc_i;
   logic                 lookup_taken_o;
   logic                 valid_o;
   logic [DATAWIDTH-1:0] next_pc_o;
   logic                 taken_o;
   logic                 mispredict_o;
   logic                 misalign_o;
   logic [31:0]          mispredict_cnt_o;

   modport slave (
      input  valid_i, pc_i, offset12_i, offset20_i, basereg_i, alu_stat_i, op_i,
             pred_taken_i, stall_i, flush_i, lookup_pc_i,
      output ready_o, lookup_taken_o, valid_o, next_pc_o, taken_o, mispredict_o,
             misalign_o, mispredict_cnt_o
   );

   modport master (
      output valid_i, pc_i, offset12_i, offset20_i, basereg_i, alu_stat_i, op_i,
             pred_taken_i, stall_i, flush_i, lookup_pc_i,
      input  ready_o, lookup_taken_o, valid_o, next_pc_o, taken_o, mispredict_o,
             misalign_o, mispredict_cnt_o
   );
endinterface

// File: rtl/beta_bju_pred.sv
// rtl/beta_bju_pred.sv - branch/jump resolve unit with 2-bit bimodal branch history table
module beta_bju_pred #(
   parameter int         DATAWIDTH = 32,
   parameter int         BHT_DEPTH = 64,
   parameter logic [1:0] BHT_INIT  = 2'b01
) (
   input logic            clk_i,
   input logic            rst_i,
   beta_bju_pred_if.slave bus
);
   localparam int IDXW = $clog2(BHT_DEPTH);

   localparam logic [1:0] BJU_BRANCH = 2'b01;
   localparam logic [1:0] BJU_JAL    = 2'b10;
   localparam logic [1:0] BJU_JALR   = 2'b11;

   logic [DATAWIDTH-1:0] seq_pc;
   logic [DATAWIDTH-1:0] br_tgt;
   logic [DATAWIDTH-1:0] jal_tgt;
   logic [DATAWIDTH-1:0] jalr_sum;
   logic [DATAWIDTH-1:0] tgt;
   logic                 cond;
   logic                 act_taken;
   logic                 act_misp;
   logic                 act_misal;
   logic                 is_branch;
   logic                 ready;
   logic                 accept;

   logic                 valid_q;
   logic [DATAWIDTH-1:0] next_pc_q;
   logic                 taken_q;
   logic                 misp_q;
   logic                 misal_q;
   logic [31:0]          misp_cnt_q;

   logic [1:0]           bht_q [BHT_DEPTH];
   logic [IDXW-1:0]      upd_idx;
   logic [IDXW-1:0]      look_idx;

   // A held result blocks new requests only while downstream stalls; flush discards the request
   assign ready  = ~(valid_q & bus.stall_i);
   assign accept = bus.valid_i & ready & ~bus.flush_i;

   assign upd_idx  = bus.pc_i[IDXW+1:2];
   assign look_idx = bus.lookup_pc_i[IDXW+1:2];

   // Resolve the control transfer: candidate targets, condition, redirect and alignment
   always_comb begin
      seq_pc    = bus.pc_i + DATAWIDTH'(4);
      br_tgt    = bus.pc_i + {{(DATAWIDTH-13){bus.offset12_i[11]}}, bus.offset12_i, 1'b0};
      jal_tgt   = bus.pc_i + {{(DATAWIDTH-21){bus.offset20_i[19]}}, bus.offset20_i, 1'b0};
      jalr_sum  = bus.basereg_i + {{(DATAWIDTH-12){bus.offset12_i[11]}}, bus.offset12_i};
      cond      = (bus.alu_stat_i[bus.op_i.exe_bju_condition_sel] == ~bus.op_i.exe_bju_condition_neg);
      is_branch = 1'b0;
      act_taken = 1'b0;
      act_misp  = 1'b0;
      tgt       = seq_pc;
      case (bus.op_i.exe_bju_en)
         BJU_BRANCH: begin
            is_branch = 1'b1;
            act_taken = cond;
            act_misp  = cond ^ bus.pred_taken_i;
            tgt       = cond ? br_tgt : seq_pc;
         end
         BJU_JAL: begin
            act_taken = 1'b1;
            act_misp  = 1'b1;
            tgt       = jal_tgt;
         end
         BJU_JALR: begin
            act_taken = 1'b1;
            act_misp  = 1'b1;
            tgt       = {jalr_sum[DATAWIDTH-1:1], 1'b0};
         end
         default: begin
            is_branch = 1'b0;
         end
      endcase
      act_misal = act_taken & (tgt[1:0] != 2'b00);
   end

   // Result register: flush drops it, accept loads it, stall holds it, otherwise it drains
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         next_pc_q <= '0;
         taken_q   <= 1'b0;
         misp_q    <= 1'b0;
         misal_q   <= 1'b0;
      end else if (bus.flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q   <= 1'b1;
         next_pc_q <= tgt;
         taken_q   <= act_taken;
         misp_q    <= act_misp;
         misal_q   <= act_misal;
      end else if (!(valid_q & bus.stall_i)) begin
         valid_q <= 1'b0;
      end
   end

   // Free-running count of accepted redirects, wraps naturally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         misp_cnt_q <= '0;
      end else if (accept & act_misp) begin
         misp_cnt_q <= misp_cnt_q + 32'd1;
      end
   end

   // Saturating 2-bit counter training on every accepted conditional branch
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= BHT_INIT;
         end
      end else if (accept & is_branch) begin
         if (act_taken) begin
            if (bht_q[upd_idx] != 2'b11) begin
               bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            end
         end else if (bht_q[upd_idx] != 2'b00) begin
            bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
         end
      end
   end

   assign bus.ready_o          = ready;
   assign bus.lookup_taken_o   = bht_q[look_idx][1];
   assign bus.valid_o          = valid_q;
   assign bus.next_pc_o        = next_pc_q;
   assign bus.taken_o          = taken_q;
   assign bus.mispredict_o     = misp_q;
   assign bus.misalign_o       = misal_q;
   assign bus.mispredict_cnt_o = misp_cnt_q;
endmodule

// File: tb/tb_beta_bju_pred.sv
// tb/tb_beta_bju_pred.sv - directed scoreboard bench for beta_bju_pred
module tb_beta_bju_pred;
   typedef struct {
      logic [31:0] npc;
      logic        t;
      logic        mp;
      logic        ma;
      logic [1:0]  en;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   beta_bju_pred_if #(.DATAWIDTH(32)) bus ();

   beta_bju_pred #(.DATAWIDTH(32), .BHT_DEPTH(64), .BHT_INIT(2'b01)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        sb[$];
   exp_t        cur;
   logic        m_valid  = 1'b0;
   logic [31:0] m_cnt    = 32'd0;
   logic [1:0]  m_bht [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_cnt   = 32'd0;
      sb.delete();
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
   endtask

   task automatic issue(input logic [1:0] en, input logic [1:0] sel, input logic neg,
                        input logic [3:0] alu, input logic pred, input logic [31:0] pc,
                        input logic [11:0] o12, input logic [19:0] o20, input logic [31:0] base);
      exp_t        e;
      logic [31:0] o12x;
      logic [31:0] o20x;
      o12x = {{20{o12[11]}}, o12};
      o20x = {{12{o20[19]}}, o20};
      e.en = en;
      e.pc = pc;
      case (en)
         2'b01: begin
            e.t   = (alu[sel] == !neg);
            e.npc = e.t ? pc + (o12x << 1) : pc + 32'd4;
            e.mp  = (e.t != pred);
         end
         2'b10: begin e.t = 1'b1; e.npc = pc + (o20x << 1); e.mp = 1'b1; end
         2'b11: begin e.t = 1'b1; e.npc = (base + o12x) & 32'hFFFF_FFFE; e.mp = 1'b1; end
         default: begin e.t = 1'b0; e.npc = pc + 32'd4; e.mp = 1'b0; end
      endcase
      e.ma = e.t && (e.npc[1:0] != 2'b00);
      sb.push_back(e);
      bus.op_i.exe_bju_en            = en;
      bus.op_i.exe_bju_condition_sel = sel;
      bus.op_i.exe_bju_condition_neg = neg;
      bus.alu_stat_i   = alu;
      bus.pred_taken_i = pred;
      bus.pc_i         = pc;
      bus.offset12_i   = o12;
      bus.offset20_i   = o20;
      bus.basereg_i    = base;
      bus.valid_i      = 1'b1;
      #1;
   endtask

   task automatic tick();
      logic acc;
      acc = bus.valid_i && !(m_valid && bus.stall_i) && !bus.flush_i;
      if (bus.valid_i && !acc && sb.size() > 0) void'(sb.pop_back());
      @(posedge clk);
      #1;
      if (acc && sb.size() > 0) begin
         cur     = sb.pop_front();
         m_valid = 1'b1;
         if (cur.mp) m_cnt = m_cnt + 32'd1;
         if (cur.en == 2'b01) begin
            if (cur.t && m_bht[cur.pc[7:2]] != 2'b11) m_bht[cur.pc[7:2]] = m_bht[cur.pc[7:2]] + 2'b01;
            else if (!cur.t && m_bht[cur.pc[7:2]] != 2'b00) m_bht[cur.pc[7:2]] = m_bht[cur.pc[7:2]] - 2'b01;
         end
      end else if (bus.flush_i || !(m_valid && bus.stall_i)) begin
         m_valid = 1'b0;
      end
      bus.valid_i = 1'b0;
      check("valid_o", bus.valid_o, m_valid);
      check("mispredict_cnt_o", bus.mispredict_cnt_o, m_cnt);
      if (m_valid) begin
         check("next_pc_o", bus.next_pc_o, cur.npc);
         check("taken_o", bus.taken_o, cur.t);
         check("mispredict_o", bus.mispredict_o, cur.mp);
         check("misalign_o", bus.misalign_o, cur.ma);
      end
   endtask

   task automatic look(input string tag, input logic [31:0] pc);
      logic [1:0] c;
      bus.lookup_pc_i = pc;
      #1;
      c = m_bht[pc[7:2]];
      check(tag, bus.lookup_taken_o, c[1]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      model_reset();
      bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
      bus.pc_i = '0; bus.offset12_i = '0; bus.offset20_i = '0; bus.basereg_i = '0;
      bus.alu_stat_i = '0; bus.op_i = '0; bus.pred_taken_i = 1'b0; bus.lookup_pc_i = 32'h100;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_o", bus.valid_o, 32'd0);
      check("rst_next_pc_o", bus.next_pc_o, 32'd0);
      check("rst_taken_o", bus.taken_o, 32'd0);
      check("rst_mispredict_o", bus.mispredict_o, 32'd0);
      check("rst_misalign_o", bus.misalign_o, 32'd0);
      check("rst_cnt", bus.mispredict_cnt_o, 32'd0);
      check("rst_ready_o", bus.ready_o, 32'd1);
      check("rst_lookup", bus.lookup_taken_o, 32'd0);
      rst = 1'b0;

      // first taken branch with not-taken prediction
      issue(2'b01, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h100, 12'h008, 20'h0, 32'h0);
      look("lookup_before_update", 32'h100);
      check("lookup_before_literal", bus.lookup_taken_o, 32'd0);
      tick();
      check("first_npc_literal", bus.next_pc_o, 32'h110);
      check("first_cnt_literal", bus.mispredict_cnt_o, 32'd1);
      look("lookup_after_update", 32'h100);
      check("lookup_after_literal", bus.lookup_taken_o, 32'd1);

      // train the same slot: taken x2 (saturate high), not-taken x4 (saturate low), taken x2
      pat = 8'b1100_0011;
      for (int i = 1; i < 8; i++) begin
         issue(2'b01, 2'd0, 1'b0, {3'b000, pat[i]}, i[0], 32'h100, 12'h008, 20'h0, 32'h0);
         tick();
         look("lookup_train", 32'h100);
      end

      // negated condition, negative offset
      issue(2'b01, 2'd2, 1'b1, 4'b0000, 1'b1, 32'h408, 12'hFFE, 20'h0, 32'h0);
      tick();
      check("neg_branch_npc_literal", bus.next_pc_o, 32'h404);

      // JALR with misaligned target
      issue(2'b11, 2'd0, 1'b0, 4'b0000, 1'b0, 32'h500, 12'hFFF, 20'h0, 32'h1003);
      tick();
      check("jalr_npc_literal", bus.next_pc_o, 32'h1002);
      check("jalr_misalign_literal", bus.misalign_o, 32'd1);

      // JAL wrapping below zero
      issue(2'b10, 2'd0, 1'b0, 4'b0000, 1'b0, 32'h0, 12'h0, 20'hFFFFF, 32'h0);
      tick();
      check("jal_npc_literal", bus.next_pc_o, 32'hFFFF_FFFE);

      // plain instruction, then stall 3 cycles, then flush
      issue(2'b00, 2'd0, 1'b0, 4'b0000, 1'b1, 32'h200, 12'h0, 20'h0, 32'h0);
      tick();
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(2'b01, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h304, 12'h010, 20'h0, 32'h0);
         check("stall_ready_o", bus.ready_o, 32'd0);
         tick();
         check("stall_hold_npc_literal", bus.next_pc_o, 32'h204);
      end
      bus.flush_i = 1'b1;
      issue(2'b01, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h304, 12'h010, 20'h0, 32'h0);
      tick();
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      check("flush_valid_literal", bus.valid_o, 32'd0);
      look("flush_no_bht", 32'h304);
      check("flush_no_bht_literal", bus.lookup_taken_o, 32'd0);

      // accept after flush, then idle drains
      issue(2'b00, 2'd0, 1'b0, 4'b0000, 1'b0, 32'h600, 12'h0, 20'h0, 32'h0);
      tick();
      tick();

      // asynchronous reset with a result held
      issue(2'b01, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h100, 12'h008, 20'h0, 32'h0);
      tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_valid", bus.valid_o, 32'd0);
      check("async_rst_cnt", bus.mispredict_cnt_o, 32'd0);
      check("async_rst_npc", bus.next_pc_o, 32'd0);
      look("async_rst_lookup", 32'h100);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(2'b01, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h100, 12'h008, 20'h0, 32'h0);
      tick();
      check("post_rst_cnt_literal", bus.mispredict_cnt_o, 32'd1);
      look("post_rst_lookup", 32'h100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/beta_bju_pred.md
BETA_BJU_PRED -- requirements
Module: beta_bju_pred

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: width of PC, operand and target datapaths.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of 2-bit predictor counters; power of two, at least 2.
REQ-003 SHALL have parameter BHT_INIT, default 2'b01: reset value of every counter (weakly not-taken).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port valid_i, input, 1 bit: resolve request present.
REQ-007 SHALL have port ready_o, output, 1 bit: request accepted this cycle.
REQ-008 SHALL have port pc_i, input, DATAWIDTH bits: PC of the resolving instruction.
REQ-009 SHALL have port offset12_i, input, 12 bits: branch/JALR immediate.
REQ-010 SHALL have port offset20_i, input, 20 bits: JAL immediate.
REQ-011 SHALL have port basereg_i, input, DATAWIDTH bits: rs1 data for JALR.
REQ-012 SHALL have port alu_stat_i, input, exe_alu_status_t: ALU status flags.
REQ-013 SHALL have port op_i, input, exe_bju_op_t: exe_bju_en, exe_bju_condition_sel, exe_bju_condition_neg.
REQ-014 SHALL have port pred_taken_i, input, 1 bit: fetch-time prediction for this instruction.
REQ-015 SHALL have port stall_i, input, 1 bit: downstream cannot take the result.
REQ-016 SHALL have port flush_i, input, 1 bit: discard held result and current request.
REQ-017 SHALL have port lookup_pc_i, input, DATAWIDTH bits: fetch PC to predict.
REQ-018 SHALL have port lookup_taken_o, output, 1 bit: prediction for lookup_pc_i.
REQ-019 SHALL have port valid_o, output, 1 bit: result registers hold a valid result.
REQ-020 SHALL have port next_pc_o, output, DATAWIDTH bits: resolved next PC.
REQ-021 SHALL have port taken_o, output, 1 bit: control transfer taken.
REQ-022 SHALL have port mispredict_o, output, 1 bit: fetch redirect required.
REQ-023 SHALL have port misalign_o, output, 1 bit: taken target not 4-byte aligned.
REQ-024 SHALL have port mispredict_cnt_o, output, 32 bits: count of mispredicts.

Function
REQ-025 SHALL assert ready_o = ~(valid_o & stall_i); acceptance = valid_i & ready_o & ~flush_i.
REQ-026 SHALL register an accepted result into the output registers at the next edge (latency 1), setting valid_o=1.
REQ-027 SHALL hold all result outputs stable while valid_o & stall_i.
REQ-028 SHALL clear valid_o when no request is accepted and not stalled.
REQ-029 SHALL, on flush_i, clear valid_o at the next edge; flush_i has priority over stall_i and valid_i; no BHT or counter update.
REQ-030 SHALL, for exe_bju_en=00, produce next_pc=pc_i+4, taken=0, mispredict=0, misalign=0, no BHT update.
REQ-031 SHALL, for exe_bju_en=01 (branch), set actual taken = (alu_stat_i[condition_sel] == ~condition_neg).
REQ-032 SHALL, for a taken branch, use target pc_i + sext({offset12_i,1'b0}); for not-taken, pc_i+4.
REQ-033 SHALL, for a branch, set mispredict = taken XOR pred_taken_i.
REQ-034 SHALL, for exe_bju_en=10 (JAL), use target pc_i + sext({offset20_i,1'b0}), taken=1, mispredict=1.
REQ-035 SHALL, for exe_bju_en=11 (JALR), use target (basereg_i + sext(offset12_i)) with bit 0 forced to 0, taken=1, mispredict=1.
REQ-036 SHALL perform all address arithmetic modulo 2^DATAWIDTH (wrap, no overflow flag).
REQ-037 SHALL set misalign = taken & (target[1:0] != 0); next_pc_o still carries the target.
REQ-038 SHALL index the BHT with pc[log2(BHT_DEPTH)+1:2], both for lookups and updates.
REQ-039 SHALL, on an accepted branch, update its counter saturating: +1 if taken (max 3), -1 if not (min 0).
REQ-040 SHALL drive lookup_taken_o combinationally = counter[1] at the lookup index; a same-cycle update is visible only after the edge.
REQ-041 SHALL increment mispredict_cnt_o by 1 per accepted result with mispredict=1, wrapping 0xFFFFFFFF->0.

Reset
REQ-042 SHALL, while rst_i=1, force valid_o, taken_o, mispredict_o, misalign_o=0, next_pc_o=0 and mispredict_cnt_o=0, and set all counters to BHT_INIT, asynchronously.
REQ-043 SHALL discard a result in flight when reset asserts mid-operation; the first accept after reset deassertion behaves as from power-up.

Verification
REQ-044 SHALL cover: after reset, branch pc=0x100, offset12=0x008, condition met, pred_taken=0 -> next cycle valid_o=1, next_pc_o=0x110, taken_o=1, mispredict_o=1, mispredict_cnt_o=1.
REQ-045 SHALL cover: the same branch 3 times taken -> counter 01->10->11->11; lookup_taken_o for lookup_pc_i=0x100 reads 0 before the first update edge, 1 after it.
REQ-046 SHALL cover: JALR basereg=0x1003, offset12=0xFFF -> next_pc_o=0x1002, taken_o=1, misalign_o=1.
REQ-047 SHALL cover: JAL pc=0x0, offset20=0xFFFFF -> next_pc_o=0xFFFFFFFE (wrap), misalign_o=1.
REQ-048 SHALL cover: stall_i held 3 cycles with valid_o=1 -> ready_o=0, outputs unchanged; then flush_i=1 with valid_i=1 -> valid_o=0 next cycle, no BHT or counter change.
